booth_radix4_sequencer: RTL and testbench

//  Sequential radix-4 Booth multiplier controller for the NPU MAC datapath.

---
 rtl/booth_radix4_sequencer.sv | 122 ++++++++++++
 tb/tb_booth_radix4_sequencer.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/booth_radix4_sequencer.sv
// Sequential radix-4 Booth multiplier controller: drives the external partial-product
// selects one digit per cycle and accumulates the sign-corrected result into Product.
module booth_radix4_sequencer #(
  parameter int Data_Width = 4
) (
  input  logic                    Clk,
  input  logic                    Rst,
  input  logic                    Start,
  input  logic [Data_Width-1:0]   Multiplicant,
  input  logic [Data_Width-1:0]   Multiplier,
  output logic [Data_Width-1:0]   Mcand_Out,
  output logic                    Shift,
  output logic                    Negation,
  output logic                    Zero,
  input  logic [Data_Width:0]     PP_In,
  output logic                    Busy,
  output logic                    Done,
  output logic [2*Data_Width-1:0] Product
);

  localparam int D  = Data_Width;
  localparam int N  = D / 2;
  localparam int CW = $clog2(N);
  localparam int QW = $clog2(D + 1);
  localparam int AW = 2 * D + 2;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t        state, state_nxt;
  logic [D-1:0]  mplier;
  logic [CW-1:0] cnt;
  logic [AW-1:0] acc, acc_nxt, pp_ext;
  logic [D:0]    qext;
  logic [QW-1:0] base;
  logic [2:0]    trip;
  logic          last, accept, sgn;

  assign last   = (cnt == CW'(N - 1));
  assign accept = Start && (state != RUN);

  always_ff @(posedge Clk) begin
    if (Rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (Start) state_nxt = RUN;
      RUN:     if (last) state_nxt = DONE;
      DONE:    state_nxt = Start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Triplet {Q[2i+1], Q[2i], Q[2i-1]} with Q[-1] supplied by the appended zero.
  assign qext = {mplier, 1'b0};
  assign base = QW'(cnt) << 1;
  assign trip = qext[base +: 3];

  always_comb begin
    Busy     = 1'b0;
    Done     = 1'b0;
    Shift    = 1'b0;
    Negation = 1'b0;
    Zero     = 1'b1;
    case (state)
      RUN: begin
        Busy = 1'b1;
        case (trip)
          3'b001, 3'b010: Zero = 1'b0;
          3'b011: begin
            Zero  = 1'b0;
            Shift = 1'b1;
          end
          3'b100: begin
            Zero     = 1'b0;
            Shift    = 1'b1;
            Negation = 1'b1;
          end
          3'b101, 3'b110: begin
            Zero     = 1'b0;
            Negation = 1'b1;
          end
          default: Zero = 1'b1;
        endcase
      end
      DONE:    Done = 1'b1;
      default: ;
    endcase
  end

  // PP_In[D] is wrong for -2M with M at the negative limit, so the true sign is
  // derived from the selects and M instead.
  assign sgn     = ~Zero & (|Mcand_Out) & (Negation ^ Mcand_Out[D-1]);
  assign pp_ext  = {{(AW-D-2){sgn}}, sgn, PP_In};
  assign acc_nxt = acc + (pp_ext << {cnt, 1'b0});

  always_ff @(posedge Clk) begin
    if (Rst) begin
      Mcand_Out <= '0;
      mplier    <= '0;
      cnt       <= '0;
      acc       <= '0;
      Product   <= '0;
    end else if (accept) begin
      Mcand_Out <= Multiplicant;
      mplier    <= Multiplier;
      cnt       <= '0;
      acc       <= '0;
    end else if (state == RUN) begin
      acc <= acc_nxt;
      cnt <= cnt + 1'b1;
      if (last) Product <= acc_nxt[2*D-1:0];
    end
  end

endmodule

// File: tb/tb_booth_radix4_sequencer.sv
// Bench for booth_radix4_sequencer at D=4 and D=8 with a behavioural partial-product
// stand-in and a signed-multiply reference.
module tb_booth_radix4_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       start4, sh4, ng4, zr4, busy4, done4;
  logic [3:0] m4, q4, mc4;
  logic [4:0] pp4, mag4;
  logic [7:0] prod4;

  logic        start8, sh8, ng8, zr8, busy8, done8;
  logic [7:0]  m8, q8, mc8;
  logic [8:0]  pp8, mag8;
  logic [15:0] prod8;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] m;
    logic [3:0] q;
    logic [7:0] exp;
  } vec_t;
  vec_t tbl[8];

  booth_radix4_sequencer #(.Data_Width(4)) u4 (
    .Clk(clk), .Rst(rst), .Start(start4), .Multiplicant(m4), .Multiplier(q4),
    .Mcand_Out(mc4), .Shift(sh4), .Negation(ng4), .Zero(zr4), .PP_In(pp4),
    .Busy(busy4), .Done(done4), .Product(prod4)
  );

  booth_radix4_sequencer #(.Data_Width(8)) u8 (
    .Clk(clk), .Rst(rst), .Start(start8), .Multiplicant(m8), .Multiplier(q8),
    .Mcand_Out(mc8), .Shift(sh8), .Negation(ng8), .Zero(zr8), .PP_In(pp8),
    .Busy(busy8), .Done(done8), .Product(prod8)
  );

  // Partial-product sub-module stand-in: +-M or +-2M truncated to D+1 bits.
  assign mag4 = sh4 ? {mc4, 1'b0} : {mc4[3], mc4};
  assign pp4  = zr4 ? '0 : (ng4 ? -mag4 : mag4);
  assign mag8 = sh8 ? {mc8, 1'b0} : {mc8[7], mc8};
  assign pp8  = zr8 ? '0 : (ng8 ? -mag8 : mag8);

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic wait_done4(output int lat);
    lat = -1;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      if (done4) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic wait_done8(output int lat);
    lat = -1;
    for (int n = 1; n <= 30; n++) begin
      @(posedge clk); #1;
      if (done8) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic op4(input logic [3:0] m, input logic [3:0] q, output logic [7:0] p, output int lat);
    @(posedge clk); #1;
    start4 = 1'b1; m4 = m; q4 = q;
    @(posedge clk); #1;
    start4 = 1'b0; m4 = 4'($urandom); q4 = 4'($urandom);
    wait_done4(lat);
    p = prod4;
  endtask

  task automatic op8(input logic [7:0] m, input logic [7:0] q, output logic [15:0] p, output int lat);
    @(posedge clk); #1;
    start8 = 1'b1; m8 = m; q8 = q;
    @(posedge clk); #1;
    start8 = 1'b0; m8 = 8'($urandom); q8 = 8'($urandom);
    wait_done8(lat);
    p = prod8;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat, ma, qa;
    logic [7:0]  p4, e4;
    logic [15:0] p8, e8;
    logic [3:0]  rm4, rq4;
    logic [7:0]  rm8, rq8;
    logic        saw_done;

    rst = 1'b1; start4 = 1'b0; start8 = 1'b0;
    m4 = '0; q4 = '0; m8 = '0; q8 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy4", busy4, 0);
    chk("rst_done4", done4, 0);
    chk("rst_prod4", prod4, 0);
    chk("rst_mcand4", mc4, 0);
    chk("rst_sel4", {sh4, ng4, zr4}, 3'b001);
    chk("rst_busy8", busy8, 0);
    chk("rst_prod8", prod8, 0);
    rst = 1'b0;

    tbl[0] = '{4'h3, 4'h5, 8'h0F};
    tbl[1] = '{4'h8, 4'h8, 8'h40};
    tbl[2] = '{4'h8, 4'h7, 8'hC8};
    tbl[3] = '{4'h0, 4'hB, 8'h00};
    tbl[4] = '{4'h7, 4'h0, 8'h00};
    tbl[5] = '{4'hF, 4'hF, 8'h01};
    tbl[6] = '{4'h7, 4'h8, 8'hC8};
    tbl[7] = '{4'h8, 4'h1, 8'hF8};
    for (int i = 0; i < 8; i++) begin
      op4(tbl[i].m, tbl[i].q, p4, lat);
      chk($sformatf("tbl%0d_prod", i), p4, tbl[i].exp);
      chk($sformatf("tbl%0d_lat", i), lat, 2);
    end

    // Digit selects for M=-8, Q=-8: digit 0 is zero, digit 1 is -2M.
    @(posedge clk); #1;
    chk("idle_sel", {sh4, ng4, zr4}, 3'b001);
    start4 = 1'b1; m4 = 4'h8; q4 = 4'h8;
    @(posedge clk); #1;
    start4 = 1'b0;
    chk("m8q8_busy", busy4, 1);
    chk("m8q8_sel0", {sh4, ng4, zr4}, 3'b001);
    @(posedge clk); #1;
    chk("m8q8_sel1", {sh4, ng4, zr4}, 3'b110);
    @(posedge clk); #1;
    chk("m8q8_done", done4, 1);
    chk("m8q8_prod", prod4, 8'h40);
    chk("done_sel", {sh4, ng4, zr4}, 3'b001);

    // Start during RUN is ignored.
    @(posedge clk); #1;
    start4 = 1'b1; m4 = 4'h3; q4 = 4'h5;
    @(posedge clk); #1;
    m4 = 4'hF; q4 = 4'h7;
    @(posedge clk); #1;
    start4 = 1'b0;
    wait_done4(lat);
    chk("runstart_lat", lat, 1);
    chk("runstart_prod", prod4, 8'h0F);
    @(posedge clk); #1;
    chk("runstart_busy", busy4, 0);
    chk("runstart_done", done4, 0);

    // Start during DONE: back-to-back with no IDLE cycle.
    op4(4'h3, 4'h5, p4, lat);
    chk("b2b_first", p4, 8'h0F);
    start4 = 1'b1; m4 = 4'h8; q4 = 4'h7;
    @(posedge clk); #1;
    start4 = 1'b0;
    chk("b2b_busy", busy4, 1);
    chk("b2b_done", done4, 0);
    wait_done4(lat);
    chk("b2b_lat", lat, 2);
    chk("b2b_prod", prod4, 8'hC8);

    // Reset mid-operation aborts without a Done pulse.
    @(posedge clk); #1;
    start4 = 1'b1; m4 = 4'h3; q4 = 4'h5;
    @(posedge clk); #1;
    start4 = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rstrun_busy", busy4, 0);
    chk("rstrun_done", done4, 0);
    chk("rstrun_prod", prod4, 0);
    chk("rstrun_sel", {sh4, ng4, zr4}, 3'b001);
    saw_done = 1'b0;
    for (int n = 0; n < 4; n++) begin
      @(posedge clk); #1;
      if (done4) saw_done = 1'b1;
    end
    chk("rstrun_nodone", saw_done, 0);

    for (int i = 0; i < 40; i++) begin
      rm4 = 4'($urandom); rq4 = 4'($urandom);
      ma = $signed(rm4); qa = $signed(rq4);
      e4 = 8'(ma * qa);
      op4(rm4, rq4, p4, lat);
      chk($sformatf("rnd4_%0d_prod m=%0d q=%0d", i, ma, qa), p4, e4);
      chk($sformatf("rnd4_%0d_lat", i), lat, 2);
    end

    op8(8'h80, 8'h80, p8, lat);
    chk("d8_min_prod", p8, 16'h4000);
    chk("d8_min_lat", lat, 4);
    op8(8'h80, 8'h7F, p8, lat);
    chk("d8_minmax_prod", p8, 16'hC080);
    for (int i = 0; i < 30; i++) begin
      rm8 = 8'($urandom); rq8 = 8'($urandom);
      ma = $signed(rm8); qa = $signed(rq8);
      e8 = 16'(ma * qa);
      op8(rm8, rq8, p8, lat);
      chk($sformatf("rnd8_%0d_prod m=%0d q=%0d", i, ma, qa), p8, e8);
      chk($sformatf("rnd8_%0d_lat", i), lat, 4);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
